pll_clken_gen: RTL and testbench
================================

Name: pll_clken_gen

Overview:
Parametrised, lock-qualified clock-enable generator that runs in a PLL output domain. It supervises the PLL locked indication and holds all outputs off until lock has been stable for a programmable time. Once lock is qualified, it produces NUM_CH independent fractional-rate clock-enable pulse trains from phase accumulators, each with its own programmable rate and phase. Downstream logic then derives multiple rates from one PLL clock instead of instantiating extra PLL outputs.

Parameters:
NUM_CH, 4, number of enable channels (1..8)
ACC_W, 32, phase accumulator width in bits (8..48)
LOCK_CYCLES, 1024, consecutive synchronised locked-high cycles needed before RUN (>=2)
LCNT_W, $clog2(LOCK_CYCLES+1), lock counter width (derived; do not override)

Ports:
refclk  in  1  block clock (PLL output domain)
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL locked flag; asynchronous to refclk, synchronised internally by two flops
ch_inc  in  NUM_CH*ACC_W  per-channel increment word; channel i occupies bits [i*ACC_W +: ACC_W]
ch_phase  in  NUM_CH*ACC_W  per-channel accumulator preload value
ch_enable  in  NUM_CH  per-channel run enable
resync  in  1  single-cycle request to reload all accumulators from ch_phase
lock_lost_clr  in  1  clears the lock_lost flag
clk_en  out  NUM_CH  per-channel enable pulses, each one refclk cycle wide
ready  out  1  high while in RUN
lock_lost  out  1  sticky flag: lock dropped while in RUN

Behaviour:
- Reset (rst_n low, asynchronous): state=WAIT_LOCK; synchroniser flops=0; lock counter=0; all accumulators=0; clk_en=0; ready=0; lock_lost=0.
- lk denotes the second synchroniser flop. pll_locked therefore has 2 cycles of latency to lk.
- FSM:
  - WAIT_LOCK: counter=0. If lk=1, go to STABLE.
  - STABLE: counter increments each cycle while lk=1. If lk=0, go to WAIT_LOCK and clear the counter. When the counter reaches LOCK_CYCLES-1 with lk=1, go to RUN and load every accumulator with its ch_phase.
  - RUN: ready=1 (registered, asserted the first cycle in RUN). If lk=0, go to WAIT_LOCK, set lock_lost=1, force clk_en=0 and clear the accumulators, all on the next edge.
- Lock qualification timing: ready rises LOCK_CYCLES+1 cycles after the first lk=1 cycle, i.e. LOCK_CYCLES+3 cycles after pll_locked rises.
- Accumulator, per channel i, in RUN with ch_enable[i]=1:
  - {carry, acc_i} <= acc_i + inc_i, computed in ACC_W+1 bits.
  - clk_en[i] <= carry, registered in the same edge as the accumulator update.
  - Pulse rate = f_refclk * inc_i / 2^ACC_W. inc_i=0 never pulses.
  - Wrap-around is modulo 2^ACC_W with no saturation.
- ch_enable[i]=0: acc_i holds its value and clk_en[i]=0. When re-enabled, accumulation continues from the held value.
- Outside RUN: clk_en=0 and the accumulators are not advanced.
- ch_inc / ch_phase changes: sampled every cycle, so a new ch_inc takes effect on the next edge. ch_phase is used only at a load event.
- resync=1 in RUN: every accumulator loads its ch_phase and clk_en=0 for that edge, overriding normal accumulation. resync outside RUN is ignored.
- Simultaneous events:
  - Lock loss together with resync: lock loss wins.
  - lock_lost_clr together with a new lock-loss event: the set wins (lock_lost stays 1).
- ready falls on the edge where the FSM leaves RUN. No clk_en pulse is produced after ready deasserts.

Decomposition:
- Shared package pll_clken_pkg holds:
  - the state enum (WAIT_LOCK, STABLE, RUN);
  - the ACC_W default;
  - a rate-to-increment helper function used by testbenches.
- One natural sub-module, clken_phase_acc: a single-channel accumulator plus carry register, with ports for load, enable, phase and increment. It is instantiated NUM_CH times with a generate loop.
- The top level holds the synchroniser, the FSM, the lock counter and lock_lost.

Test Plan:
- Lock qualification: LOCK_CYCLES=16, pll_locked raised at cycle 10 and held -> ready=1 at cycle 29; clk_en=0 through cycle 28.
- Lock glitch: pll_locked drops for 1 cycle midway through STABLE -> counter restarts; ready is delayed by the full 16 cycles after lk returns high.
- Rate: ACC_W=32, ch_inc[0]=0x4000_0000, ch_phase=0 -> clk_en[0] pulses every 4th cycle. ch_inc[1]=0x5555_5556 -> 3000 pulses in 9000 cycles, +/-1.
- Phase and resync: ch0 and ch1 with inc 0x4000_0000 and phases 0 and 0x8000_0000 -> ch1 pulses 2 cycles before ch0. After resync, the same offset is re-established and no pulse occurs in the resync cycle.
- Lock loss in RUN: drop pll_locked -> within 3 cycles ready=0, clk_en=0 and lock_lost=1. lock_lost stays 1 across relock until lock_lost_clr is pulsed.
- Reset mid-RUN: assert rst_n low asynchronously between edges -> all outputs 0 immediately. After release the block starts again from WAIT_LOCK.

Source files
------------

// File: rtl/pll_clken_pkg.sv
// Shared definitions for the lock-qualified clock-enable generator.
package pll_clken_pkg;

  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Increment word for a pulse rate of num/den of refclk, rounded up so the
  // produced rate never falls below the request (e.g. 1/3 -> 0x5555_5556).
  function automatic logic [63:0] rate_to_inc(input int unsigned num,
                                              input int unsigned den,
                                              input int unsigned acc_w);
    logic [127:0] scaled;
    scaled = (128'(num) << acc_w) + 128'(den) - 128'd1;
    return 64'(scaled / 128'(den));
  endfunction

endpackage

// File: rtl/clken_phase_acc.sv
// Single-channel phase accumulator; the carry out of each addition becomes
// a one-cycle enable pulse registered on the same edge.
module clken_phase_acc
  import pll_clken_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [ACC_W-1:0] phase,
  input  logic [ACC_W-1:0] inc,
  output logic             pulse
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // Priority: clear (lock loss) > preload > accumulate > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      pulse <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      pulse <= 1'b0;
    end else if (load) begin
      acc   <= phase;
      pulse <= 1'b0;
    end else if (en) begin
      acc   <= sum[ACC_W-1:0];
      pulse <= sum[ACC_W];
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_clken_gen.sv
// Lock-qualified fractional clock-enable generator in the PLL output domain.
// Outputs stay quiet until the synchronised lock flag has been high for
// LOCK_CYCLES consecutive cycles; then NUM_CH accumulators generate pulses.
module pll_clken_gen
  import pll_clken_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = 1024,
  parameter int LCNT_W      = $clog2(LOCK_CYCLES + 1)
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] ch_inc,
  input  logic [NUM_CH*ACC_W-1:0] ch_phase,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    resync,
  input  logic                    lock_lost_clr,
  output logic [NUM_CH-1:0]       clk_en,
  output logic                    ready,
  output logic                    lock_lost
);

  logic              sync1;
  logic              lk;
  state_t            state;
  state_t            next_state;
  logic [LCNT_W-1:0] cnt;
  logic [LCNT_W-1:0] cnt_next;
  logic              load_all;
  logic              lost_evt;
  logic              run_adv;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  // State, lock counter, ready and sticky lock_lost registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      ready <= (next_state == RUN);
      if (lost_evt) begin
        lock_lost <= 1'b1;
      end else if (lock_lost_clr) begin
        lock_lost <= 1'b0;
      end
    end
  end

  // Next-state logic: qualify lock, then run until lk drops.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    load_all   = 1'b0;
    lost_evt   = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (lk) next_state = STABLE;
      end
      STABLE: begin
        if (!lk) begin
          next_state = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == LCNT_W'(LOCK_CYCLES - 1)) begin
          next_state = RUN;
          cnt_next   = '0;
          load_all   = 1'b1;
        end else begin
          cnt_next = cnt + LCNT_W'(1);
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lk) begin
          next_state = WAIT_LOCK;
          lost_evt   = 1'b1;
        end else if (resync) begin
          load_all = 1'b1;
        end
      end
      default: begin
        next_state = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // Accumulators advance only in RUN with lock held and no resync pending.
  assign run_adv = (state == RUN) && lk && !resync;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clken_phase_acc #(
      .ACC_W (ACC_W)
    ) u_acc (
      .clk   (refclk),
      .rst_n (rst_n),
      .clr   (lost_evt),
      .load  (load_all),
      .en    (run_adv && ch_enable[i]),
      .phase (ch_phase[i*ACC_W +: ACC_W]),
      .inc   (ch_inc[i*ACC_W +: ACC_W]),
      .pulse (clk_en[i])
    );
  end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed bench for pll_clken_gen with NUM_CH=4, ACC_W=32, LOCK_CYCLES=16.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pll_clken_gen;
  import pll_clken_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int ACC_W       = 32;
  localparam int LOCK_CYCLES = 16;

  logic                    refclk;
  logic                    rst_n;
  logic                    pll_locked;
  logic [NUM_CH*ACC_W-1:0] ch_inc;
  logic [NUM_CH*ACC_W-1:0] ch_phase;
  logic [NUM_CH-1:0]       ch_enable;
  logic                    resync;
  logic                    lock_lost_clr;
  logic [NUM_CH-1:0]       clk_en;
  logic                    ready;
  logic                    lock_lost;

  int checks = 0;
  int errors = 0;

  pll_clken_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .ch_inc        (ch_inc),
    .ch_phase      (ch_phase),
    .ch_enable     (ch_enable),
    .resync        (resync),
    .lock_lost_clr (lock_lost_clr),
    .clk_en        (clk_en),
    .ready         (ready),
    .lock_lost     (lock_lost)
  );

  // Clock
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Expected clk_en k edges after a load with the channel setup below:
  // ch0 inc 1/4 phase 0, ch1 inc 1/4 phase 1/2, ch2 inc ~1/3 phase 0, ch3 inc 0.
  function automatic logic [3:0] pat(input int k);
    logic [3:0] v;
    v    = 4'b0000;
    v[0] = (k % 4 == 0);
    v[1] = (k % 4 == 2);
    v[2] = (k % 3 == 0);
    return v;
  endfunction

  // Driver: raise lock and confirm ready rises exactly 19 edges later.
  task automatic relock(input string tag);
    logic seen;
    seen = 1'b0;
    pll_locked = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      seen = seen | ready;
    end
    check({tag, "_early"}, seen, 1'b0);
    tick();
    check({tag, "_ready"}, ready, 1'b1);
  endtask

  initial begin
    logic [31:0] inc3;
    logic        rdy_seen;
    logic [3:0]  en_seen;
    int          c0, c2, c3;

    rst_n         = 1'b0;
    pll_locked    = 1'b0;
    resync        = 1'b0;
    lock_lost_clr = 1'b0;
    ch_enable     = 4'b1111;
    inc3          = 32'(rate_to_inc(1, 3, ACC_W));
    check("rate_fn", inc3, 32'h5555_5556);
    ch_inc   = {32'h0, inc3, 32'h4000_0000, 32'h4000_0000};
    ch_phase = {32'h0, 32'h0, 32'h8000_0000, 32'h0};

    // Reset state
    #12;
    check("rst_ready", ready, 1'b0);
    check("rst_clk_en", clk_en, 4'h0);
    check("rst_lock_lost", lock_lost, 1'b0);
    @(negedge refclk);
    rst_n = 1'b1;

    // Lock qualification: lock raised after edge 10, ready after edge 29
    rdy_seen = 1'b0;
    en_seen  = 4'h0;
    for (int e = 1; e <= 28; e++) begin
      tick();
      if (e == 10) pll_locked = 1'b1;
      rdy_seen = rdy_seen | ready;
      en_seen  = en_seen | clk_en;
    end
    check("qual_no_ready", rdy_seen, 1'b0);
    check("qual_no_clk_en", en_seen, 4'h0);
    tick();
    check("qual_ready", ready, 1'b1);

    // Phase pattern after the lock load
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("run_pattern", clk_en, pat(k));
    end

    // Channel 0 disabled: no pulses on it
    ch_enable = 4'b1110;
    c0 = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      c0 += int'(clk_en[0]);
    end
    check("disabled_ch0", c0, 0);
    ch_enable = 4'b1111;

    // Resync: quiet edge, then the same phase pattern again
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("resync_quiet", clk_en, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("resync_pattern", clk_en, pat(k));
    end

    // Rate over 9000 edges from a fresh resync
    resync = 1'b1;
    tick();
    resync = 1'b0;
    c0 = 0; c2 = 0; c3 = 0;
    for (int k = 1; k <= 9000; k++) begin
      tick();
      c0 += int'(clk_en[0]);
      c2 += int'(clk_en[2]);
      c3 += int'(clk_en[3]);
    end
    check("rate_ch0", c0, 2250);
    check("rate_ch2", c2, 3000);
    check("rate_ch3", c3, 0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick();
    tick();
    check("loss_ready_d2", ready, 1'b1);
    check("loss_flag_d2", lock_lost, 1'b0);
    tick();
    check("loss_ready", ready, 1'b0);
    check("loss_clk_en", clk_en, 4'h0);
    check("loss_flag", lock_lost, 1'b1);
    en_seen = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      en_seen = en_seen | clk_en;
    end
    check("loss_quiet", en_seen, 4'h0);

    // Relock keeps the sticky flag until cleared
    relock("relock1");
    check("sticky_flag", lock_lost, 1'b1);
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    check("flag_cleared", lock_lost, 1'b0);

    // Lock loss coinciding with clear and resync: set wins
    pll_locked = 1'b0;
    tick();
    tick();
    lock_lost_clr = 1'b1;
    resync        = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    resync        = 1'b0;
    check("simul_flag", lock_lost, 1'b1);
    check("simul_ready", ready, 1'b0);
    check("simul_clk_en", clk_en, 4'h0);

    // Reset asserted mid-RUN between edges
    relock("relock2");
    #3;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #1;
    check("arst_ready", ready, 1'b0);
    check("arst_clk_en", clk_en, 4'h0);
    check("arst_flag", lock_lost, 1'b0);
    tick();
    rst_n = 1'b1;

    // Lock glitch during STABLE restarts qualification
    rdy_seen = 1'b0;
    en_seen  = 4'h0;
    for (int e = 1; e <= 39; e++) begin
      tick();
      if (e == 10) pll_locked = 1'b1;
      if (e == 20) pll_locked = 1'b0;
      if (e == 21) pll_locked = 1'b1;
      rdy_seen = rdy_seen | ready;
      en_seen  = en_seen | clk_en;
    end
    check("glitch_no_ready", rdy_seen, 1'b0);
    check("glitch_no_clk_en", en_seen, 4'h0);
    tick();
    check("glitch_ready", ready, 1'b1);
    tick();
    check("glitch_pattern", clk_en, pat(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
